nvr_mem_ctrl: RTL

Sequencing controller between the processor's data/instruction memory port and one NVR_TOP non-volatile memory macro. It accepts single-word read/write requests over a valid/ready handshake and drives the macro's strobe protocol in clock cycles: address/WE setup, CE pulse, WE hold, then waiting for RDY. It also runs the macro's power-on (POR) sequence after reset. It replaces the timing tasks currently hand-coded in the processor benches with synthesizable RTL.

---
 rtl/nvr_mem_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/nvr_mem_ctrl.sv
// nvr_mem_ctrl: sequences single-word read/write requests onto the NVR_TOP
// macro strobe protocol (setup, CE pulse, WE hold, wait for RDY) and runs the
// macro power-on pulse after reset. All macro strobes are registered.
module nvr_mem_ctrl #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 1,
  parameter int unsigned HOLD_CYC    = 7,
  parameter int unsigned POR_CYC     = 10,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_init_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_A,
  output logic [DATA_W-1:0] o_mem_DIN,
  output logic              o_mem_CE,
  output logic              o_mem_WE,
  output logic              o_mem_POR,
  output logic              o_mem_HS,
  output logic              o_mem_HR,
  input  logic [DATA_W-1:0] i_mem_DOUT,
  input  logic              i_mem_RDY
);

  localparam logic [3:0] S_POR_PULSE = 4'd0;
  localparam logic [3:0] S_POR_WAIT  = 4'd1;
  localparam logic [3:0] S_IDLE      = 4'd2;
  localparam logic [3:0] S_SETUP     = 4'd3;
  localparam logic [3:0] S_STROBE    = 4'd4;
  localparam logic [3:0] S_HOLD      = 4'd5;
  localparam logic [3:0] S_WAIT_RDY  = 4'd6;
  localparam logic [3:0] S_RESP      = 4'd7;
  localparam logic [3:0] S_DEAD      = 4'd8;

  // POR_PULSE includes the reset-release cycle, so it exits at count POR_CYC
  localparam logic [15:0] L_POR_LAST   = 16'(POR_CYC);
  localparam logic [15:0] L_SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] L_PULSE_LAST = 16'(PULSE_CYC - 1);
  localparam logic [15:0] L_HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] L_TO_LAST    = 16'(TIMEOUT_CYC - 1);

  logic [3:0]        r_state;
  logic [15:0]       r_cnt;
  logic              r_rdy_m;
  logic              r_rdy_s;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rsp_err;
  logic              r_rsp_valid;
  logic              r_ready;
  logic              r_ce;
  logic              r_we;
  logic              r_por;
  logic              r_init_done;
  logic              r_err;

  logic [3:0]        w_state_nxt;
  logic              w_accept;
  logic              w_write_nxt;
  logic              w_acc_ok;
  logic              w_acc_to;
  logic              w_por_to;

  assign w_accept    = i_req_valid && r_ready && (r_state == S_IDLE);
  assign w_write_nxt = w_accept ? i_req_write : r_write;

  // Two-flop synchronizer for the asynchronous macro ready
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rdy_m <= 1'b0;
      r_rdy_s <= 1'b0;
    end else begin
      r_rdy_m <= i_mem_RDY;
      r_rdy_s <= r_rdy_m;
    end
  end

  // Next-state decode; RDY is ignored in the first wait cycle so the sync flushes
  always_comb begin
    w_state_nxt = r_state;
    w_acc_ok    = 1'b0;
    w_acc_to    = 1'b0;
    w_por_to    = 1'b0;
    case (r_state)
      S_POR_PULSE: if (r_cnt == L_POR_LAST) w_state_nxt = S_POR_WAIT;
      S_POR_WAIT: begin
        if ((r_cnt != '0) && r_rdy_s) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == L_TO_LAST) begin
          w_state_nxt = S_DEAD;
          w_por_to    = 1'b1;
        end
      end
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  if (r_cnt == L_SETUP_LAST) w_state_nxt = S_STROBE;
      S_STROBE: if (r_cnt == L_PULSE_LAST) w_state_nxt = r_write ? S_HOLD : S_WAIT_RDY;
      S_HOLD:   if (r_cnt == L_HOLD_LAST) w_state_nxt = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if ((r_cnt != '0) && r_rdy_s) begin
          w_state_nxt = S_RESP;
          w_acc_ok    = 1'b1;
        end else if (r_cnt == L_TO_LAST) begin
          w_state_nxt = S_RESP;
          w_acc_to    = 1'b1;
        end
      end
      S_RESP:   w_state_nxt = S_IDLE;
      S_DEAD:   w_state_nxt = S_DEAD;
      default:  w_state_nxt = S_POR_PULSE;
    endcase
  end

  // State register and per-state cycle counter (restarts on every state change)
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_POR_PULSE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // Registered strobes decoded from the next state so they are glitch-free
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ce        <= 1'b0;
      r_we        <= 1'b0;
      r_por       <= 1'b0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_ce        <= (w_state_nxt == S_STROBE);
      r_we        <= (((w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE)) && w_write_nxt)
                     || (w_state_nxt == S_HOLD);
      r_por       <= (w_state_nxt == S_POR_PULSE);
      r_ready     <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
    end
  end

  // Request capture and response data; mem_DIN keeps its last write value on reads
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_rdata   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write   <= i_req_write;
        r_addr    <= i_req_addr;
        r_rsp_err <= 1'b0;
        if (i_req_write) r_din <= i_req_wdata;
      end
      if (w_acc_ok && !r_write) begin
        r_rdata <= i_mem_DOUT;
      end else if (w_acc_to) begin
        r_rdata   <= '0;
        r_rsp_err <= 1'b1;
      end
    end
  end

  // Init-done and sticky error flags, cleared only by reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if ((r_state == S_POR_WAIT) && (w_state_nxt == S_IDLE)) r_init_done <= 1'b1;
      if (w_acc_to || w_por_to) r_err <= 1'b1;
    end
  end

  assign o_req_ready = r_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_init_done = r_init_done;
  assign o_err       = r_err;
  assign o_mem_A     = r_addr;
  assign o_mem_DIN   = r_din;
  assign o_mem_CE    = r_ce;
  assign o_mem_WE    = r_we;
  assign o_mem_POR   = r_por;
  assign o_mem_HS    = 1'b0;
  assign o_mem_HR    = 1'b0;

endmodule
